// File: rtl/key_pkg.sv
// Shared constants, FSM state type and key map for the PS/2 key event decoder.
package key_pkg;

    localparam logic [7:0] KEY_EXT    = 8'hE0;
    localparam logic [7:0] KEY_BRK    = 8'hF0;
    localparam logic [7:0] KEY_IDLE   = 8'h00;
    localparam logic [7:0] KEY_BAT    = 8'hAA;
    localparam logic [7:0] KEY_ECHO   = 8'hEE;
    localparam logic [7:0] KEY_ACK    = 8'hFA;
    localparam logic [7:0] KEY_RESEND = 8'hFE;

    localparam int NUM_KEYS = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK
    } kstate_e;

    function automatic logic is_ignored(input logic [7:0] code);
        return (code == KEY_IDLE) || (code == KEY_BAT) || (code == KEY_ECHO) ||
               (code == KEY_ACK)  || (code == KEY_RESEND);
    endfunction

    // Returns {hit, index}; index is meaningless when hit is 0
    function automatic logic [4:0] key_index(input logic [7:0] code);
        logic [4:0] r;
        case (code)
            8'h1C:   r = 5'h10;
            8'h1B:   r = 5'h11;
            8'h23:   r = 5'h12;
            8'h2B:   r = 5'h13;
            8'h34:   r = 5'h14;
            8'h33:   r = 5'h15;
            8'h3B:   r = 5'h16;
            8'h42:   r = 5'h17;
            8'h4B:   r = 5'h18;
            8'h1D:   r = 5'h19;
            8'h24:   r = 5'h1A;
            8'h2C:   r = 5'h1B;
            8'h35:   r = 5'h1C;
            8'h3C:   r = 5'h1D;
            8'h44:   r = 5'h1E;
            8'h4C:   r = 5'h1F;
            default: r = 5'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/byte_sync_filter.sv
// Two-flop synchroniser, stability filter and change strobe for the
// asynchronous PS/2 latest-byte bus.
module byte_sync_filter #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte,
    output logic       o_strobe
);

    localparam logic [3:0] CNT_MAX  = 4'(STABLE_CYCLES);
    localparam logic [3:0] CNT_LAST = 4'(STABLE_CYCLES - 1);

    logic [7:0] s1_q, s1_d;
    logic [7:0] s2_q, s2_d;
    logic [7:0] cand_q, cand_d;
    logic [7:0] acc_q, acc_d;
    logic [3:0] cnt_q, cnt_d;
    logic       strobe_q, strobe_d;

    always_comb begin
        s1_d     = i_byte;
        s2_d     = s1_q;
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        strobe_d = 1'b0;
        if (s2_q != cand_q) begin
            cand_d = s2_q;
            cnt_d  = '0;
        end else begin
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 4'd1;
            end
            // Bits may skew across the sync, so only a settled byte is taken
            if (cnt_q == CNT_LAST) begin
                acc_d    = cand_q;
                strobe_d = (cand_q != acc_q);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_q     <= '0;
            s2_q     <= '0;
            cand_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            strobe_q <= 1'b0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            cand_q   <= cand_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            strobe_q <= strobe_d;
        end
    end

    assign o_byte   = acc_q;
    assign o_strobe = strobe_q;

endmodule

// File: rtl/key_event_decoder.sv
// Scan-code set 2 prefix decoder producing key events and a held-key mask
// for the 16 synth keys.
module key_event_decoder
    import key_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [7:0]          i_key,
    output logic                o_evt_valid,
    output logic                o_evt_make,
    output logic                o_evt_ext,
    output logic [7:0]          o_evt_code,
    output logic [NUM_KEYS-1:0] o_key_mask,
    output logic                o_any_key
);

    logic [7:0] byte_w;
    logic       strobe_w;

    byte_sync_filter #(
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_filter (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_byte  (i_key),
        .o_byte  (byte_w),
        .o_strobe(strobe_w)
    );

    kstate_e             state_q, state_d;
    logic                valid_q, valid_d;
    logic                make_q, make_d;
    logic                ext_q, ext_d;
    logic [7:0]          code_q, code_d;
    logic [NUM_KEYS-1:0] mask_q, mask_d;

    logic       brk_seen;
    logic       ext_seen;
    logic [4:0] map_w;

    always_comb begin
        state_d  = state_q;
        valid_d  = 1'b0;
        make_d   = make_q;
        ext_d    = ext_q;
        code_d   = code_q;
        mask_d   = mask_q;
        brk_seen = (state_q == ST_BRK) || (state_q == ST_EXT_BRK);
        ext_seen = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
        map_w    = key_index(byte_w);
        if (strobe_w) begin
            if (is_ignored(byte_w)) begin
                state_d = ST_IDLE;
            end else if (byte_w == KEY_EXT) begin
                state_d = brk_seen ? ST_EXT_BRK : ST_EXT;
            end else if (byte_w == KEY_BRK) begin
                state_d = ext_seen ? ST_EXT_BRK : ST_BRK;
            end else begin
                valid_d = 1'b1;
                make_d  = !brk_seen;
                ext_d   = ext_seen;
                code_d  = byte_w;
                state_d = ST_IDLE;
                // Extended codes alias base codes, so they stay off the mask
                if (!ext_seen && map_w[4]) begin
                    mask_d[map_w[3:0]] = !brk_seen;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            make_q  <= 1'b0;
            ext_q   <= 1'b0;
            code_q  <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            make_q  <= make_d;
            ext_q   <= ext_d;
            code_q  <= code_d;
            mask_q  <= mask_d;
        end
    end

    assign o_evt_valid = valid_q;
    assign o_evt_make  = make_q;
    assign o_evt_ext   = ext_q;
    assign o_evt_code  = code_q;
    assign o_key_mask  = mask_q;
    assign o_any_key   = |mask_q;

endmodule

// File: tb/tb_key_event_decoder.sv
// Scoreboard bench: directed scenarios plus random byte streams checked
// against a prefix/mask reference model.
module tb_key_event_decoder;

    localparam int STABLE = 4;
    localparam int LAT    = STABLE + 4;

    logic        clk = 1'b0;
    logic        i_rst;
    logic [7:0]  i_key;
    logic        o_evt_valid;
    logic        o_evt_make;
    logic        o_evt_ext;
    logic [7:0]  o_evt_code;
    logic [15:0] o_key_mask;
    logic        o_any_key;

    key_event_decoder #(
        .STABLE_CYCLES(STABLE)
    ) dut (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .i_key      (i_key),
        .o_evt_valid(o_evt_valid),
        .o_evt_make (o_evt_make),
        .o_evt_ext  (o_evt_ext),
        .o_evt_code (o_evt_code),
        .o_key_mask (o_key_mask),
        .o_any_key  (o_any_key)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  code;
        logic        make;
        logic        ext;
        logic [15:0] mask;
        int          t;
    } exp_t;

    exp_t q[$];
    int   cyc  = 0;
    int   nvec = 0;
    int   nerr = 0;

    logic [7:0]  cur;
    logic [7:0]  acc_m;
    logic        ext_m;
    logic        brk_m;
    logic [15:0] mask_m;

    logic [7:0] keymap [16] = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33,
                                8'h3B, 8'h42, 8'h4B, 8'h1D, 8'h24, 8'h2C,
                                8'h35, 8'h3C, 8'h44, 8'h4C};
    logic [7:0] ignore [5] = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE};
    logic [7:0] pool [14]  = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h75,
                               8'hE0, 8'hF0, 8'h00, 8'hAA, 8'h12, 8'h4C,
                               8'h44, 8'hE0};

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: called once a byte has been held long enough to count
    task automatic model(input logic [7:0] b, input int t);
        exp_t e;
        bit   ign;
        int   idx;
        if (b == acc_m) return;
        acc_m = b;
        ign = 0;
        foreach (ignore[i]) if (ignore[i] == b) ign = 1;
        if (ign) begin
            ext_m = 0;
            brk_m = 0;
        end else if (b == 8'hE0) begin
            ext_m = 1;
        end else if (b == 8'hF0) begin
            brk_m = 1;
        end else begin
            idx = -1;
            foreach (keymap[i]) if (keymap[i] == b) idx = i;
            if (!ext_m && idx >= 0) mask_m[idx] = !brk_m;
            e.code = b;
            e.make = !brk_m;
            e.ext  = ext_m;
            e.mask = mask_m;
            e.t    = t;
            q.push_back(e);
            ext_m = 0;
            brk_m = 0;
        end
    endtask

    task automatic apply(input logic [7:0] b, input int h);
        int c;
        c = cyc;
        i_key = b;
        cur = b;
        for (int n = 1; n <= h; n++) begin
            @(negedge clk);
            if (n == STABLE + 1) model(b, c + LAT);
        end
    endtask

    task automatic do_reset();
        int n;
        n = 0;
        while (q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        nvec++;
        if (q.size() != 0) begin
            nerr++;
            $display("FAIL drain: pending=%0d required=0", q.size());
            q.delete();
        end
        i_rst = 1;
        i_key = 8'h00;
        cur = 8'h00;
        @(negedge clk);
        i_rst = 0;
        acc_m = 0;
        ext_m = 0;
        brk_m = 0;
        mask_m = 0;
        nvec++;
        if ({o_evt_valid, o_evt_make, o_evt_ext, o_evt_code, o_key_mask, o_any_key} != 0) begin
            nerr++;
            $display("FAIL reset_state: v=%b m=%b x=%b code=%h mask=%h any=%b required all 0",
                     o_evt_valid, o_evt_make, o_evt_ext, o_evt_code, o_key_mask, o_any_key);
        end
        @(negedge clk);
        nvec++;
        if (o_evt_valid !== 1'b0) begin
            nerr++;
            $display("FAIL post_reset_valid: got=%b required=0", o_evt_valid);
        end
    endtask

    task automatic check_mask(input string nm);
        nvec++;
        if (o_key_mask !== mask_m || o_any_key !== (mask_m != 0)) begin
            nerr++;
            $display("FAIL %s: mask=%h any=%b required mask=%h any=%b",
                     nm, o_key_mask, o_any_key, mask_m, mask_m != 0);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!i_rst && o_evt_valid === 1'b1) begin
            nvec++;
            if (q.size() == 0) begin
                nerr++;
                $display("FAIL unexpected_evt: code=%h make=%b ext=%b at cyc %0d required none",
                         o_evt_code, o_evt_make, o_evt_ext, cyc);
            end else begin
                e = q.pop_front();
                if (o_evt_code !== e.code || o_evt_make !== e.make || o_evt_ext !== e.ext ||
                    o_key_mask !== e.mask || o_any_key !== (e.mask != 0) || cyc != e.t) begin
                    nerr++;
                    $display("FAIL evt: got code=%h make=%b ext=%b mask=%h any=%b cyc=%0d required code=%h make=%b ext=%b mask=%h any=%b cyc=%0d",
                             o_evt_code, o_evt_make, o_evt_ext, o_key_mask, o_any_key, cyc,
                             e.code, e.make, e.ext, e.mask, e.mask != 0, e.t);
                end
            end
        end
    end

    initial begin
        logic [7:0] b;
        i_rst = 1;
        i_key = 8'h00;
        cur = 8'h00;
        acc_m = 0;
        ext_m = 0;
        brk_m = 0;
        mask_m = 0;
        repeat (3) @(negedge clk);
        do_reset();

        apply(8'h1C, 30);
        check_mask("t1_mask");
        apply(8'hF0, 12);
        apply(8'h1C, 12);
        check_mask("t2_mask");
        apply(8'hE0, 12);
        apply(8'h75, 12);
        apply(8'hE0, 12);
        apply(8'hF0, 12);
        apply(8'h75, 12);
        check_mask("t3_mask");
        apply(8'h00, 12);
        apply(8'h1B, 3);
        apply(8'h00, 12);
        check_mask("t4_glitch_mask");
        apply(8'h1B, 5);
        apply(8'h00, 12);
        check_mask("t4_mask");
        apply(8'h1C, 12);
        apply(8'h1B, 12);
        check_mask("t5_held_mask");
        apply(8'hF0, 12);
        do_reset();
        check_mask("t5_reset_mask");
        apply(8'h1C, 12);
        check_mask("t5_mask");
        apply(8'hF0, 12);
        apply(8'hAA, 12);
        apply(8'hFA, 12);
        apply(8'h00, 12);
        apply(8'h23, 12);
        check_mask("t6_mask");

        for (int s = 0; s < 400; s++) begin
            if ($urandom_range(0, 59) == 0) begin
                apply((cur == 8'h00) ? 8'hAA : 8'h00, 12);
                do_reset();
            end
            b = cur;
            while (b == cur) b = pool[$urandom_range(0, 13)];
            apply(b, $urandom_range(1, 12));
        end
        apply((cur == 8'h00) ? 8'hAA : 8'h00, 20);
        nvec++;
        if (q.size() != 0) begin
            nerr++;
            $display("FAIL leftover: pending=%0d required=0", q.size());
        end
        check_mask("final_mask");
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
